// File: rtl/series_adder_result_axis.sv
// Result-stream capture stage: buffers the non-backpressured result words in a FIFO and
// re-emits them as an AXI4-Stream master, with framing checks and packet/drop counters.
module series_adder_result_axis #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              proto_err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [DATA_W+1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_in_rdy;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tuser;
    logic              r_tlast;
    logic              r_tvalid;
    logic              r_overflow;
    logic              r_proto_err;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    state_t            r_state;

    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic [DATA_W+1:0] w_head;
    logic [ADDR_W:0]   w_level_nxt;
    state_t            w_state_nxt;
    logic              w_err_set;

    // Acceptance looks only at the level at cycle start; a same-cycle pop frees nothing.
    assign w_full = (r_level == LVL_FULL);
    assign w_push = in_vld && !w_full;
    assign w_drop = in_vld && w_full;
    assign w_pop  = (r_level != LVL_ZERO) && (!r_tvalid || m_axis_tready);
    assign w_head = r_mem[r_rd_ptr];

    // Occupancy update from push/pop pair
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // FIFO storage; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_first, in_last, in_data};
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_wr_ptr <= {ADDR_W{1'b0}};
            r_rd_ptr <= {ADDR_W{1'b0}};
            r_level  <= LVL_ZERO;
            r_in_rdy <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level  <= w_level_nxt;
            r_in_rdy <= (w_level_nxt != LVL_FULL);
        end
    end

    // AXI output register: reload from FIFO head whenever the slot is free or draining
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_tdata  <= {DATA_W{1'b0}};
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_pop) begin
            r_tuser  <= w_head[DATA_W+1];
            r_tlast  <= w_head[DATA_W];
            r_tdata  <= w_head[DATA_W-1:0];
            r_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= r_tvalid;
        end
    end

    // Framing FSM next state: a last word always closes the packet, otherwise one is open
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        if (in_vld) begin
            w_state_nxt = in_last ? S_IDLE : S_PKT;
            case (r_state)
                S_IDLE:  w_err_set = !in_first;
                S_PKT:   w_err_set = in_first;
                default: w_err_set = 1'b0;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Framing state and sticky error/overflow flags plus wrapping counters
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state     <= S_IDLE;
            r_proto_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_pkt_cnt   <= {CNT_W{1'b0}};
            r_drop_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
            if (r_tvalid && m_axis_tready && r_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_ONE;
            end
        end
    end

    assign in_rdy        = r_in_rdy;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;
    assign proto_err     = r_proto_err;
    assign pkt_cnt       = r_pkt_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule
